fifo_uart_tx: RTL and testbench

- Downstream consumer of the 4-deep byte FIFO.
- Pops bytes from the FIFO read port and serialises them as 8-N-1 UART frames (optional parity) on a single TXD line.
- Sits between the FIFO and the board serial pin. Handles the FIFO's registered-read latency: data appears one clock after the read enable is sampled.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/fifo_uart_tx.sv | 128 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Even parity when odd = 0; setting odd inverts it.
    function automatic logic frame_parity(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last SYSCLK cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic SYSCLK,
    input  logic RST_B,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge SYSCLK) begin
        if (!RST_B || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_end = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops bytes from a registered-read FIFO and sends 8-N-1 frames
// (optional parity) on TXD, LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       SYSCLK,
    input  logic       RST_B,
    input  logic       TX_EN,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_DATA,
    output logic       FIFO_RD_EN,
    output logic       TXD,
    output logic       BUSY,
    output logic       TX_DONE
);

    tx_state_t                 state_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      parity_reg;
    logic [2:0]                bit_idx_reg;
    logic                      bit_end;
    logic                      baud_clr;
    logic                      fetch_ok;

    // Hold the timer at zero outside the serial bits so START always gets a full period.
    assign baud_clr = (state_reg == IDLE) || (state_reg == FETCH) || (state_reg == LOAD);
    assign fetch_ok = TX_EN && !FIFO_EMPTY;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .SYSCLK  (SYSCLK),
        .RST_B   (RST_B),
        .clr     (baud_clr),
        .bit_end (bit_end)
    );

    always_ff @(posedge SYSCLK) begin
        if (!RST_B) begin
            state_reg   <= IDLE;
            TXD         <= UART_IDLE_LEVEL;
            FIFO_RD_EN  <= 1'b0;
            BUSY        <= 1'b0;
            TX_DONE     <= 1'b0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_idx_reg <= '0;
        end else begin
            FIFO_RD_EN <= 1'b0;
            TX_DONE    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    TXD <= UART_IDLE_LEVEL;
                    if (fetch_ok) begin
                        FIFO_RD_EN <= 1'b1;
                        BUSY       <= 1'b1;
                        state_reg  <= FETCH;
                    end
                end
                // FIFO_EMPTY is stale here: the FIFO only updates it after the pop.
                FETCH: begin
                    state_reg <= LOAD;
                end
                LOAD: begin
                    shift_reg   <= FIFO_DATA;
                    parity_reg  <= frame_parity(FIFO_DATA, PARITY_ODD);
                    TXD         <= 1'b0;
                    bit_idx_reg <= '0;
                    state_reg   <= START;
                end
                START: begin
                    if (bit_end) begin
                        TXD         <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                TXD       <= parity_reg;
                                state_reg <= PARITY;
                            end else begin
                                TXD       <= UART_IDLE_LEVEL;
                                state_reg <= STOP;
                            end
                        end else begin
                            TXD         <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        TXD       <= UART_IDLE_LEVEL;
                        state_reg <= STOP;
                    end
                end
                // Chaining straight into FETCH keeps BUSY high and adds only FETCH+LOAD to the stop bit.
                STOP: begin
                    if (bit_end) begin
                        TX_DONE <= 1'b1;
                        if (fetch_ok) begin
                            FIFO_RD_EN <= 1'b1;
                            state_reg  <= FETCH;
                        end else begin
                            BUSY      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    TXD       <= UART_IDLE_LEVEL;
                    BUSY      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) fed by FIFO models, checked each
// cycle against a frame-level reference model plus directed frame tables and corner sequences.
module tb_fifo_uart_tx;

    localparam int N  = 4;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b;
    logic       tx_en      [NI];
    logic       fifo_empty [NI];
    logic [7:0] fifo_data  [NI];
    logic       rd_en      [NI];
    logic       txd        [NI];
    logic       busy       [NI];
    logic       done       [NI];

    // FIFO models: bench pushes, DUT pops with registered-read latency.
    logic [7:0] mem    [NI][16];
    int         wr_cnt [NI] = '{default: 0};
    int         rd_cnt [NI] = '{default: 0};

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference model: frame offset c (cycles since the pop request edge), -1 when idle.
    int         c        [NI];
    logic [7:0] cur      [NI];
    int         mref     [NI];
    logic       fetch_s  [NI];
    logic       rst_s;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            fifo_uart_tx #(
                .CLKS_PER_BIT (N),
                .PARITY_EN    (gi != 0),
                .PARITY_ODD   (gi == 2)
            ) u_dut (
                .SYSCLK     (clk),
                .RST_B      (rst_b),
                .TX_EN      (tx_en[gi]),
                .FIFO_EMPTY (fifo_empty[gi]),
                .FIFO_DATA  (fifo_data[gi]),
                .FIFO_RD_EN (rd_en[gi]),
                .TXD        (txd[gi]),
                .BUSY       (busy[gi]),
                .TX_DONE    (done[gi])
            );
            assign fifo_empty[gi] = (wr_cnt[gi] == rd_cnt[gi]);
        end
    endgenerate

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rd_en[i] === 1'b1 && wr_cnt[i] != rd_cnt[i]) begin
                fifo_data[i] <= mem[i][4'(rd_cnt[i])];
                rd_cnt[i]    <= rd_cnt[i] + 1;
            end else begin
                fifo_data[i] <= 8'($urandom);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][4'(wr_cnt[i])] = b;
        wr_cnt[i]++;
    endtask

    // Frame bit j: 0 = start, 1..8 = data LSB first, 9 = parity (if enabled), then stop.
    function automatic logic frame_bit(input int i, input logic [7:0] b, input int j);
        logic [7:0] s;
        if (j == 0) return 1'b0;
        if (j <= 8) begin
            s = b >> (j - 1);
            return s[0];
        end
        if (j == 9 && i != 0) return (^b) ^ (i == 2);
        return 1'b1;
    endfunction

    task automatic start_frame(input int i);
        c[i]   = 0;
        cur[i] = mem[i][4'(mref[i])];
        mref[i]++;
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic       exp_done;
            logic       exp_txd;
            logic [3:0] exp_v;
            logic [3:0] act_v;
            int         flen;
            flen     = 2 + ((i == 0) ? 10 : 11) * N;
            exp_done = 1'b0;
            if (!rst_s) begin
                c[i] = -1;
            end else if (c[i] >= 0) begin
                c[i]++;
                if (c[i] == flen) begin
                    exp_done = 1'b1;
                    $display("inst %0d: frame 0x%02h complete at cycle %0d", i, cur[i], cycle);
                    c[i] = -1;
                    if (fetch_s[i]) start_frame(i);
                end
            end else if (fetch_s[i]) begin
                start_frame(i);
            end
            exp_txd = (c[i] < 2) ? 1'b1 : frame_bit(i, cur[i], (c[i] - 2) / N);
            exp_v   = {c[i] == 0, exp_txd, c[i] >= 0, exp_done};
            act_v   = {rd_en[i], txd[i], busy[i], done[i]};
            check($sformatf("model inst%0d rd/txd/busy/done", i), 32'(act_v), 32'(exp_v));
        end
    endtask

    // One clock: capture what the DUT will sample at the next edge, pass the edge, then check.
    task automatic tick();
        rst_s = rst_b;
        for (int i = 0; i < NI; i++) fetch_s[i] = tx_en[i] && (wr_cnt[i] != rd_cnt[i]);
        @(negedge clk);
        cycle++;
        model_step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_rd(input int i, input string name);
        int n;
        n = 0;
        while (rd_en[i] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(rd_en[i]), 32'd1);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        tx_en[i] = 1'b1;
        while ((wr_cnt[i] != rd_cnt[i] || busy[i] !== 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        check($sformatf("drain inst%0d idle", i), 32'(busy[i]), 32'd0);
        check($sformatf("drain inst%0d fifo left", i), 32'(wr_cnt[i] - rd_cnt[i]), 32'd0);
        tx_en[i] = 1'b0;
    endtask

    typedef struct {
        int          inst;
        logic [7:0]  data;
        int          nbits;
        logic [10:0] pat;
    } row_t;

    row_t rows [6];

    initial begin
        int   rds;
        int   bad;
        int   flen;
        logic ok;
        logic sh [$];
        int   rd_t [$];
        logic [10:0] p;

        rows[0] = '{inst: 0, data: 8'hA5, nbits: 10, pat: 11'b011_0100_1010};
        rows[1] = '{inst: 0, data: 8'h3C, nbits: 10, pat: 11'b010_0111_1000};
        rows[2] = '{inst: 1, data: 8'h03, nbits: 11, pat: 11'b100_0000_0110};
        rows[3] = '{inst: 2, data: 8'h03, nbits: 11, pat: 11'b110_0000_0110};
        rows[4] = '{inst: 1, data: 8'h80, nbits: 11, pat: 11'b111_0000_0000};
        rows[5] = '{inst: 2, data: 8'hFF, nbits: 11, pat: 11'b111_1111_1110};

        rst_b = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tx_en[i] = 1'b0;
            c[i]     = -1;
            mref[i]  = 0;
            cur[i]   = 8'h00;
        end

        ticks(2);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset inst%0d rd/txd/busy/done", i),
                  32'({rd_en[i], txd[i], busy[i], done[i]}), 32'b0100);
        end
        rst_b = 1'b1;
        tick();

        // TX_EN low with data waiting: nothing moves for 100 cycles.
        push(0, 8'h11);
        bad = 0;
        repeat (100) begin
            tick();
            if (rd_en[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        check("gated idle cycles", 32'(bad), 32'd0);
        drain(0);

        // Directed single frames, including the empty-start latency.
        for (int r = 0; r < 6; r++) begin
            int i;
            i    = rows[r].inst;
            flen = 2 + rows[r].nbits * N;
            tx_en[i] = 1'b1;
            tick();
            check($sformatf("row%0d no rd while empty", r), 32'(rd_en[i]), 32'd0);
            push(i, rows[r].data);
            tick();
            check($sformatf("row%0d rd one cycle after empty falls", r), 32'(rd_en[i]), 32'd1);
            for (int k = 1; k <= flen; k++) begin
                tick();
                if (k == 1) check($sformatf("row%0d rd single pulse", r), 32'(rd_en[i]), 32'd0);
                if (k == 2) check($sformatf("row%0d txd falls at k+2", r), 32'(txd[i]), 32'd0);
                if (k >= 2 && k < flen && ((k - 2) % N) == N / 2) begin
                    p = rows[r].pat >> ((k - 2) / N);
                    check($sformatf("row%0d bit%0d", r, (k - 2) / N), 32'(txd[i]), 32'(p[0]));
                end
                if (k == flen - 1) check($sformatf("row%0d done early", r), 32'(done[i]), 32'd0);
                if (k == flen) begin
                    check($sformatf("row%0d tx_done", r), 32'(done[i]), 32'd1);
                    check($sformatf("row%0d busy after", r), 32'(busy[i]), 32'd0);
                end
            end
            tx_en[i] = 1'b0;
            tick();
        end

        // Back-to-back: four queued bytes, frames chained with a 2-cycle gap.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        push(0, 8'h81);
        tx_en[0] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            sh.push_back(txd[0]);
            if (rd_en[0] === 1'b1) rd_t.push_back(t);
        end
        check("b2b rd pulses", 32'(rd_t.size()), 32'd4);
        if (rd_t.size() == 4) begin
            for (int j = 1; j < 4; j++) begin
                check($sformatf("b2b rd spacing %0d", j), 32'(rd_t[j] - rd_t[j-1]), 32'd42);
                ok = 1'b1;
                for (int d = -4; d <= 1; d++) if (sh[rd_t[j] + d] !== 1'b1) ok = 1'b0;
                check($sformatf("b2b gap high %0d", j), 32'(ok), 32'd1);
                check($sformatf("b2b start bit %0d", j), 32'(sh[rd_t[j] + 2]), 32'd0);
            end
        end
        check("b2b idle", 32'(busy[0]), 32'd0);
        check("b2b fifo empty", 32'(fifo_empty[0]), 32'd1);
        tx_en[0] = 1'b0;

        // TX_EN dropped during the data bits: frame completes, second byte stays queued.
        push(0, 8'h5A);
        push(0, 8'hC3);
        tx_en[0] = 1'b1;
        wait_rd(0, "gate-mid first rd");
        ticks(2 + N * 3);
        tx_en[0] = 1'b0;
        rds = 0;
        repeat (60) begin
            tick();
            if (rd_en[0] === 1'b1) rds++;
        end
        check("gate-mid extra rd", 32'(rds), 32'd0);
        check("gate-mid idle", 32'(busy[0]), 32'd0);
        check("gate-mid fifo left", 32'(wr_cnt[0] - rd_cnt[0]), 32'd1);
        drain(0);

        // Reset during data bit 3 of 0xA5.
        push(0, 8'hA5);
        tx_en[0] = 1'b1;
        wait_rd(0, "reset-mid rd");
        ticks(2 + 4 * N + 1);
        rst_b = 1'b0;
        tick();
        check("reset-mid txd", 32'(txd[0]), 32'd1);
        check("reset-mid busy", 32'(busy[0]), 32'd0);
        check("reset-mid rd", 32'(rd_en[0]), 32'd0);
        rst_b = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (rd_en[0] !== 1'b0 || txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
        end
        check("reset-mid no continuation", 32'(bad), 32'd0);
        tx_en[0] = 1'b0;

        // Random traffic, enables and rare resets on all instances.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NI; i++) begin
                if ((wr_cnt[i] - rd_cnt[i]) < 4 && $urandom_range(0, 99) < 10) push(i, 8'($urandom));
                if ($urandom_range(0, 99) < 2) tx_en[i] = ~tx_en[i];
            end
            rst_b = ($urandom_range(0, 1499) != 0);
            tick();
        end
        rst_b = 1'b1;
        for (int i = 0; i < NI; i++) drain(i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
